// File: rtl/lab_color_pkg.sv
// Shared Q8.23 constants, frame defaults and scheduler state encoding
// for the Lab colour-enhancement path.
package lab_color_pkg;

    localparam logic [31:0] FX_ONE  = 32'h0080_0000;
    localparam logic [31:0] FX_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] FX_MIN  = 32'h8000_0000;
    localparam int          FX_FRAC = 23;

    localparam int          DEF_FRAME_W = 1448;
    localparam int          DEF_FRAME_H = 1072;
    localparam logic [31:0] DEF_GAIN    = 32'h00C0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_A,
        ST_MUL_B,
        ST_OUT
    } sched_state_e;

endpackage

// File: rtl/fx_mul_q8_23.sv
// Combinational Q8.23 signed multiplier: floor-truncating shift with
// saturation to the Q8.23 range on overflow.
module fx_mul_q8_23
    import lab_color_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_o
);

    logic signed [63:0] prod;
    logic               ovf;
    logic               unused_frac;

    // Result fits only when the bits above the kept window all match the sign.
    always_comb begin
        prod = 64'($signed(a_i)) * 64'($signed(b_i));
        ovf  = !((&prod[63:54]) || !(|prod[63:54]));
        if (ovf) begin
            p_o = prod[63] ? FX_MIN : FX_MAX;
        end else begin
            p_o = prod[FX_FRAC+31:FX_FRAC];
        end
    end

    assign unused_frac = ^prod[FX_FRAC-1:0];

endmodule

// File: rtl/lab_enhance_sched.sv
// Per-pixel Lab enhancement scheduler: one shared multiplier applied to A
// then B, L passed through, with frame-synchronous gain updates.
module lab_enhance_sched
    import lab_color_pkg::*;
#(
    parameter int          FRAME_W      = DEF_FRAME_W,
    parameter int          FRAME_H      = DEF_FRAME_H,
    parameter logic [31:0] DEFAULT_GAIN = DEF_GAIN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [31:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_l,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_l,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_eof,
    output logic        busy
);

    localparam int            NPIX     = FRAME_W * FRAME_H;
    localparam int            CW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

    sched_state_e  state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   out_l_q, out_l_d, out_a_q, out_a_d, out_b_q, out_b_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [31:0]   gain_stg_a_q, gain_stg_a_d, gain_stg_b_q, gain_stg_b_d;
    logic [31:0]   gain_act_a_q, gain_act_a_d, gain_act_b_q, gain_act_b_d;

    logic          accept;
    logic          out_hs;
    logic [31:0]   mul_x, mul_g, mul_p;

    assign accept = in_valid && in_ready_q && (state_q == ST_IDLE);
    assign out_hs = (state_q == ST_OUT) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_MUL_A;
            ST_MUL_A: state_d = ST_MUL_B;
            ST_MUL_B: state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    assign mul_x = (state_q == ST_MUL_B) ? b_q : a_q;
    assign mul_g = (state_q == ST_MUL_B) ? gain_act_b_q : gain_act_a_q;

    fx_mul_q8_23 u_mul (
        .a_i (mul_x),
        .b_i (mul_g),
        .p_o (mul_p)
    );

    // Active gains reload from the staged copy's current value, so a write
    // landing on the same edge as a frame-start accept waits a whole frame.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        out_l_d      = out_l_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        pix_cnt_d    = pix_cnt_q;
        gain_stg_a_d = gain_stg_a_q;
        gain_stg_b_d = gain_stg_b_q;
        gain_act_a_d = gain_act_a_q;
        gain_act_b_d = gain_act_b_q;

        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            out_l_d = in_l;
            if (pix_cnt_q == '0) begin
                gain_act_a_d = gain_stg_a_q;
                gain_act_b_d = gain_stg_b_q;
            end
        end
        if (state_q == ST_MUL_A) out_a_d = mul_p;
        if (state_q == ST_MUL_B) out_b_d = mul_p;

        if (cfg_we) begin
            if (cfg_sel) gain_stg_b_d = cfg_data;
            else         gain_stg_a_d = cfg_data;
        end

        if (out_hs) begin
            pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            out_l_q      <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            pix_cnt_q    <= '0;
            gain_stg_a_q <= DEFAULT_GAIN;
            gain_stg_b_q <= DEFAULT_GAIN;
            gain_act_a_q <= DEFAULT_GAIN;
            gain_act_b_q <= DEFAULT_GAIN;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            a_q          <= a_d;
            b_q          <= b_d;
            out_l_q      <= out_l_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            pix_cnt_q    <= pix_cnt_d;
            gain_stg_a_q <= gain_stg_a_d;
            gain_stg_b_q <= gain_stg_b_d;
            gain_act_a_q <= gain_act_a_d;
            gain_act_b_q <= gain_act_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_OUT);
    assign out_l     = out_l_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_eof   = (state_q == ST_OUT) && (pix_cnt_q == LAST_PIX);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lab_enhance_sched.sv
// Directed bench for lab_enhance_sched using a 4x2 frame so frame
// boundaries and gain reloads are reached quickly.
module tb_lab_enhance_sched;

    localparam int FW = 4;
    localparam int FH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_l = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_l;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_eof;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lab_enhance_sched #(
        .FRAME_W      (FW),
        .FRAME_H      (FH),
        .DEFAULT_GAIN (32'h00C0_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_l      (in_l),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_eof   (out_eof),
        .busy      (busy)
    );

    // Present one pixel (optionally with a cfg write on the same edge) and
    // return just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] a,
                                 input logic [31:0] b, input logic we,
                                 input logic sel, input logic [31:0] data);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_l = l;
        in_a = a;
        in_b = b;
        cfg_we = we;
        cfg_sel = sel;
        cfg_data = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
    endtask

    // Wait for out_valid (sampled at negedges), capture outputs, and let the
    // handshake edge pass when out_ready is high.
    task automatic collectOutput(output logic [31:0] l, output logic [31:0] a,
                                 output logic [31:0] b, output logic eof,
                                 output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL output_timeout: out_valid=%b, expected 1", out_valid);
        end
        l = out_l;
        a = out_a;
        b = out_b;
        eof = out_eof;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, busy, out_eof} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: valid/ready/busy/eof=%b, expected 0000",
                     {out_valid, in_ready, busy, out_eof});
        end
        checks++;
        if ({out_l, out_a, out_b} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: l=%h a=%h b=%h, expected all 0", out_l, out_a, out_b);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_edge: in_ready=%b, expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_edge: in_ready=%b, expected 1", in_ready);
        end
    endtask

    // Pixel 0 of the frame, default gain 1.5.
    task automatic test_basic();
        logic [31:0] gl, ga, gb;
        logic        ge;
        int          lat;
        applyStimulus(32'h0000_1234, 32'h0100_0000, 32'hFF00_0000, 1'b0, 1'b0, 32'h0);
        collectOutput(gl, ga, gb, ge, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles, expected 3", lat);
        end
        checks++;
        if (gl !== 32'h0000_1234) begin
            errors++;
            $display("[TB] FAIL basic_l: got %h, expected 00001234", gl);
        end
        checks++;
        if (ga !== 32'h0180_0000) begin
            errors++;
            $display("[TB] FAIL basic_a: got %h, expected 01800000", ga);
        end
        checks++;
        if (gb !== 32'hFE80_0000) begin
            errors++;
            $display("[TB] FAIL basic_b: got %h, expected fe800000", gb);
        end
        checks++;
        if (ge !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_eof: got %b, expected 0", ge);
        end
    endtask

    // Pixel 1: 254.0*1.5 and -256.0*1.5 both exceed the Q8.23 range.
    task automatic test_saturation();
        logic [31:0] gl, ga, gb;
        logic        ge;
        int          lat;
        applyStimulus(32'h0000_0ABC, 32'h7F00_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
        collectOutput(gl, ga, gb, ge, lat);
        checks++;
        if (ga !== 32'h7FFF_FFFF) begin
            errors++;
            $display("[TB] FAIL sat_pos: got %h, expected 7fffffff", ga);
        end
        checks++;
        if (gb !== 32'h8000_0000) begin
            errors++;
            $display("[TB] FAIL sat_neg: got %h, expected 80000000", gb);
        end
    endtask

    // Pixel 2: output held under backpressure, then released.
    task automatic test_backpressure();
        logic [31:0] gl, ga, gb;
        logic        ge;
        int          lat;
        out_ready = 1'b0;
        applyStimulus(32'h5555_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        collectOutput(gl, ga, gb, ge, lat);
        checks++;
        if (ga !== 32'h00C0_0000 || gb !== 32'h0 || gl !== 32'h5555_0000) begin
            errors++;
            $display("[TB] FAIL bp_values: l=%h a=%h b=%h, expected 55550000 00c00000 00000000",
                     gl, ga, gb);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                out_l !== 32'h5555_0000 || out_a !== 32'h00C0_0000 || out_b !== 32'h0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: valid=%b ready=%b busy=%b l=%h a=%h b=%h, expected 1 0 1 55550000 00c00000 00000000",
                         i, out_valid, in_ready, busy, out_l, out_a, out_b);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    // Pixels 3..7 keep 1.5 despite a write during pixel 3; next pixel 0 uses 1.0.
    task automatic test_frame_gain();
        logic [31:0] gl, ga, gb;
        logic        ge;
        int          lat;
        for (int p = 3; p < 8; p++) begin
            applyStimulus(32'(p), 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0, 32'h0);
            if (p == 3) begin
                @(negedge clk);
                cfg_we = 1'b1;
                cfg_sel = 1'b0;
                cfg_data = 32'h0080_0000;
                @(posedge clk);
                #1;
                cfg_we = 1'b0;
            end
            collectOutput(gl, ga, gb, ge, lat);
            checks++;
            if (ga !== 32'h0180_0000) begin
                errors++;
                $display("[TB] FAIL frame_old_gain[%0d]: got %h, expected 01800000", p, ga);
            end
            checks++;
            if (ge !== (p == 7)) begin
                errors++;
                $display("[TB] FAIL frame_eof[%0d]: got %b, expected %b", p, ge, (p == 7));
            end
        end
        applyStimulus(32'h0, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0, 32'h0);
        collectOutput(gl, ga, gb, ge, lat);
        checks++;
        if (ga !== 32'h0100_0000) begin
            errors++;
            $display("[TB] FAIL frame_new_gain_a: got %h, expected 01000000", ga);
        end
        checks++;
        if (gb !== 32'h0180_0000) begin
            errors++;
            $display("[TB] FAIL frame_gain_b_kept: got %h, expected 01800000", gb);
        end
    endtask

    // Write gain_a=2.0 on the frame-start accept edge: visible one frame later.
    task automatic test_same_cycle();
        logic [31:0] gl, ga, gb;
        logic        ge;
        int          lat;
        for (int p = 1; p < 8; p++) begin
            applyStimulus(32'(p), 32'h0100_0000, 32'h0, 1'b0, 1'b0, 32'h0);
            collectOutput(gl, ga, gb, ge, lat);
            checks++;
            if (ga !== 32'h0100_0000 || ge !== (p == 7)) begin
                errors++;
                $display("[TB] FAIL same_pre[%0d]: a=%h eof=%b, expected 01000000 %b",
                         p, ga, ge, (p == 7));
            end
        end
        applyStimulus(32'h0, 32'h0100_0000, 32'h0, 1'b1, 1'b0, 32'h0100_0000);
        collectOutput(gl, ga, gb, ge, lat);
        checks++;
        if (ga !== 32'h0100_0000) begin
            errors++;
            $display("[TB] FAIL same_cycle_start: got %h, expected 01000000", ga);
        end
        for (int p = 1; p < 8; p++) begin
            applyStimulus(32'(p), 32'h0100_0000, 32'h0, 1'b0, 1'b0, 32'h0);
            collectOutput(gl, ga, gb, ge, lat);
            checks++;
            if (ga !== 32'h0100_0000) begin
                errors++;
                $display("[TB] FAIL same_mid[%0d]: got %h, expected 01000000", p, ga);
            end
        end
        applyStimulus(32'h0, 32'h0100_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        collectOutput(gl, ga, gb, ge, lat);
        checks++;
        if (ga !== 32'h0200_0000) begin
            errors++;
            $display("[TB] FAIL same_next_frame: got %h, expected 02000000", ga);
        end
    endtask

    // Reset while in MUL_B with pix_cnt=1 and gain_a=2.0.
    task automatic test_reset_midop();
        logic [31:0] gl, ga, gb;
        logic        ge;
        int          lat;
        int          stale;
        applyStimulus(32'h0000_0077, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, out_eof} !== 4'b0000 || {out_l, out_a, out_b} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL midop_reset: valid=%b ready=%b busy=%b eof=%b l=%h a=%h b=%h, expected all 0",
                     out_valid, in_ready, busy, out_eof, out_l, out_a, out_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("[TB] FAIL stale_output: out_valid seen %0d cycles, expected 0", stale);
        end
        for (int p = 0; p < 8; p++) begin
            applyStimulus(32'(p), 32'h0100_0000, 32'hFF00_0000, 1'b0, 1'b0, 32'h0);
            collectOutput(gl, ga, gb, ge, lat);
            checks++;
            if (ga !== 32'h0180_0000 || gb !== 32'hFE80_0000) begin
                errors++;
                $display("[TB] FAIL post_reset_gain[%0d]: a=%h b=%h, expected 01800000 fe800000",
                         p, ga, gb);
            end
            checks++;
            if (ge !== (p == 7)) begin
                errors++;
                $display("[TB] FAIL post_reset_eof[%0d]: got %b, expected %b", p, ge, (p == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_frame_gain();
        test_same_cycle();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
